// File: rtl/alu_pkg.sv
// Shared types and constants for the LEGv8 64-bit ALU: operation encoding,
// datapath width and NZCV flag bit positions.
package alu_pkg;

  localparam int unsigned ALU_W  = 64;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_LSL   = 4'b1000,
    ALU_LSR   = 4'b1001
  } alu_op_t;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu64_if.sv
// Operand/result bundle between the datapath (master) and the ALU (slave).
interface alu64_if #(
  parameter int unsigned WIDTH = alu_pkg::ALU_W
);
  import alu_pkg::*;

  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [OP_W-1:0]   ALUControl;
  logic              flags_we;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic [FLAG_W-1:0] flags;

  modport master (
    output a, b, ALUControl, flags_we,
    input  result, zero, flags
  );

  modport slave (
    input  a, b, ALUControl, flags_we,
    output result, zero, flags
  );

endinterface

// File: rtl/alu_addsub.sv
// Single shared adder for ADD/SUB: subtraction is a + ~b + 1 via inverted b
// and carry-in, so carry-out directly gives the unsigned a >= b condition.
module alu_addsub #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  assign cout  = full[WIDTH];

  // Overflow: both adder inputs share a sign that the sum does not
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu64.sv
// 64-bit LEGv8 ALU: combinational result/zero plus a clocked NZCV register
// that captures the current operation's flags when flags_we is high.
module alu64
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic   clk,
  input  logic   reset_n,
  alu64_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;
  logic              is_add;
  logic              is_sub;
  logic [SHW-1:0]    shamt;
  logic [WIDTH-1:0]  result_c;
  logic              zero_c;
  logic [FLAG_W-1:0] nzcv_next;
  logic [FLAG_W-1:0] flags_q;

  assign is_add = (bus.ALUControl == ALU_ADD);
  assign is_sub = (bus.ALUControl == ALU_SUB);
  assign shamt  = bus.b[SHW-1:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (bus.a),
    .b    (bus.b),
    .sub  (is_sub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // Operation select; unused codes deliberately yield zero
  always_comb begin
    result_c = '0;
    case (bus.ALUControl)
      ALU_AND:   result_c = bus.a & bus.b;
      ALU_OR:    result_c = bus.a | bus.b;
      ALU_ADD:   result_c = sum;
      ALU_SUB:   result_c = sum;
      ALU_PASSB: result_c = bus.b;
      ALU_LSL:   result_c = bus.a << shamt;
      ALU_LSR:   result_c = bus.a >> shamt;
      default:   result_c = '0;
    endcase
  end

  assign zero_c = (result_c == '0);

  always_comb begin
    nzcv_next         = '0;
    nzcv_next[FLAG_N] = result_c[WIDTH-1];
    nzcv_next[FLAG_Z] = zero_c;
    nzcv_next[FLAG_C] = (is_add || is_sub) ? cout : 1'b0;
    nzcv_next[FLAG_V] = (is_add || is_sub) ? ovf  : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (bus.flags_we) begin
      flags_q <= nzcv_next;
    end
  end

  assign bus.result = result_c;
  assign bus.zero   = zero_c;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu64.sv
// Directed bench for alu64: logic/pass, add/sub wrap and flags, shifts,
// and flag register reset/enable behaviour.
module tb_alu64;
  import alu_pkg::*;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  alu64_if #(.WIDTH(64)) bus ();

  alu64 #(.WIDTH(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv);
    bus.ALUControl = op;
    bus.a          = av;
    bus.b          = bv;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (bus.flags !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000", bus.flags);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_logic();
    logic [3:0]  op [6];
    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic [63:0] er [6];
    op[0] = 4'b0000; va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h0;  er[0] = 64'h0;
    op[1] = 4'b0001; va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h0;  er[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    op[2] = 4'b0000; va[2] = 64'hFF;                  vb[2] = 64'hF0; er[2] = 64'hF0;
    op[3] = 4'b0111; va[3] = 64'h1234;                vb[3] = 64'h1;  er[3] = 64'h1;
    op[4] = 4'b0011; va[4] = 64'h5;                   vb[4] = 64'h7;  er[4] = 64'h0;
    op[5] = 4'b1111; va[5] = 64'hFFFF;                vb[5] = 64'h1;  er[5] = 64'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(op[i], va[i], vb[i]);
      #1;
      tests++;
      if (bus.result !== er[i] || bus.zero !== (er[i] == 64'h0)) begin
        fails++;
        $display("FAIL logic[%0d]: got %h/%b want %h/%b", i, bus.result, bus.zero,
                 er[i], (er[i] == 64'h0));
      end
    end
  endtask

  // ADD/SUB results, and the NZCV captured one edge later
  task automatic test_addsub();
    logic [3:0]  op [9];
    logic [63:0] va [9];
    logic [63:0] vb [9];
    logic [63:0] er [9];
    logic [3:0]  ef [9];
    op[0] = 4'b0010; va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h1;
    er[0] = 64'h0;                   ef[0] = 4'b0110;
    op[1] = 4'b0010; va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'h7FFF_FFFF_FFFF_FFFF;
    er[1] = 64'hFFFF_FFFF_FFFF_FFFE; ef[1] = 4'b1001;
    op[2] = 4'b0010; va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000;
    er[2] = 64'h0;                   ef[2] = 4'b0111;
    op[3] = 4'b0010; va[3] = 64'd100;                 vb[3] = 64'hFFFF_FFFF_FFFF_FF9C;
    er[3] = 64'h0;                   ef[3] = 4'b0110;
    op[4] = 4'b0110; va[4] = 64'hFFFF_FFFF_FFFF_FFFF; vb[4] = 64'h1;
    er[4] = 64'hFFFF_FFFF_FFFF_FFFE; ef[4] = 4'b1010;
    op[5] = 4'b0110; va[5] = 64'd200;                 vb[5] = 64'd100;
    er[5] = 64'd100;                 ef[5] = 4'b0010;
    op[6] = 4'b0110; va[6] = 64'hFFFF_FFFF_FFFF_FF9C; vb[6] = 64'hFFFF_FFFF_FFFF_FFCE;
    er[6] = 64'hFFFF_FFFF_FFFF_FFCE; ef[6] = 4'b1000;
    op[7] = 4'b0110; va[7] = 64'd50;                  vb[7] = 64'hFFFF_FFFF_FFFF_FFCE;
    er[7] = 64'd100;                 ef[7] = 4'b0000;
    op[8] = 4'b0110; va[8] = 64'd5;                   vb[8] = 64'd5;
    er[8] = 64'h0;                   ef[8] = 4'b0110;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(op[i], va[i], vb[i]);
      bus.flags_we = 1'b1;
      #1;
      tests++;
      if (bus.result !== er[i] || bus.zero !== (er[i] == 64'h0)) begin
        fails++;
        $display("FAIL addsub_result[%0d]: got %h/%b want %h/%b", i, bus.result, bus.zero,
                 er[i], (er[i] == 64'h0));
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.flags !== ef[i]) begin
        fails++;
        $display("FAIL addsub_flags[%0d]: got %b want %b", i, bus.flags, ef[i]);
      end
    end
    @(negedge clk);
    bus.flags_we = 1'b0;
  endtask

  task automatic test_shift();
    logic [3:0]  op [8];
    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic [63:0] er [8];
    op[0] = 4'b1000; va[0] = 64'hFFFF;                vb[0] = 64'd0;  er[0] = 64'hFFFF;
    op[1] = 4'b1000; va[1] = 64'hFFFF;                vb[1] = 64'd1;  er[1] = 64'h1FFFE;
    op[2] = 4'b1000; va[2] = 64'hFFFF;                vb[2] = 64'd16; er[2] = 64'hFFFF_0000;
    op[3] = 4'b1000; va[3] = 64'hFFFE;                vb[3] = 64'd63; er[3] = 64'h0;
    op[4] = 4'b1001; va[4] = 64'hFFFF;                vb[4] = 64'd1;  er[4] = 64'h7FFF;
    op[5] = 4'b1001; va[5] = 64'hFFFF_0000;           vb[5] = 64'd16; er[5] = 64'hFFFF;
    op[6] = 4'b1001; va[6] = 64'h8000_0000_0000_0000; vb[6] = 64'd63; er[6] = 64'h1;
    op[7] = 4'b1000; va[7] = 64'h1;                   vb[7] = 64'd64; er[7] = 64'h1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(op[i], va[i], vb[i]);
      #1;
      tests++;
      if (bus.result !== er[i] || bus.zero !== (er[i] == 64'h0)) begin
        fails++;
        $display("FAIL shift[%0d]: got %h/%b want %h/%b", i, bus.result, bus.zero,
                 er[i], (er[i] == 64'h0));
      end
    end
  endtask

  task automatic test_flags();
    // Load a nonzero value so the asynchronous clear is observable
    @(negedge clk);
    drive(4'b0110, 64'd3, 64'd5);
    bus.flags_we = 1'b1;
    @(negedge clk);
    bus.flags_we = 1'b0;
    tests++;
    if (bus.flags !== 4'b1000) begin
      fails++;
      $display("FAIL flags_preload: got %b want 1000", bus.flags);
    end
    drive(4'b0111, 64'h0, 64'h1234);
    #1;
    reset_n = 1'b0;
    #1;
    tests++;
    if (bus.flags !== 4'b0000) begin
      fails++;
      $display("FAIL async_reset: got %b want 0000", bus.flags);
    end
    tests++;
    if (bus.result !== 64'h1234 || bus.zero !== 1'b0) begin
      fails++;
      $display("FAIL result_in_reset: got %h/%b want 1234/0", bus.result, bus.zero);
    end
    // Enable asserted across an edge while reset is held: must not capture
    bus.flags_we = 1'b1;
    drive(4'b0110, 64'd3, 64'd5);
    @(posedge clk);
    #1;
    tests++;
    if (bus.flags !== 4'b0000) begin
      fails++;
      $display("FAIL we_in_reset: got %b want 0000", bus.flags);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.flags !== 4'b1000) begin
      fails++;
      $display("FAIL sub_3_5_flags: got %b want 1000", bus.flags);
    end
    @(negedge clk);
    bus.flags_we = 1'b0;
    drive(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.flags !== 4'b1000) begin
      fails++;
      $display("FAIL flags_hold: got %b want 1000", bus.flags);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    reset_n      = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.ALUControl = 4'b0000;
    bus.flags_we = 1'b0;
    test_reset();
    test_logic();
    test_addsub();
    test_shift();
    test_flags();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu64.md
Name: alu64

Overview:
- 64-bit integer ALU for the single-cycle/pipelined LEGv8 (ARM subset) datapath.
- `result` and `zero` are purely combinational from `a`, `b` and `ALUControl`; they feed branch (CBZ) and memory-address logic directly.
- An NZCV condition-flag register, clocked and updated on request, provides flags for conditional branches.

Parameters:
- WIDTH, 64, operand/result width; all behaviour below is defined for 64.

Ports:
- clk  input  1  system clock; only the flag register uses it.
- reset_n  input  1  asynchronous, active-low reset.
- a  input  64  operand A; also the shift source.
- b  input  64  operand B; also the shift amount (bits [5:0] only).
- ALUControl  input  4  operation select.
- flags_we  input  1  when high, capture NZCV on the next rising clk edge.
- result  output  64  combinational operation result.
- zero  output  1  combinational; 1 iff result == 0.
- flags  output  4  registered {N,Z,C,V}.

Behaviour:
- Operation encoding (combinational, zero latency, settles within the same delta/cycle):
  - 0000 AND: result = a & b.
  - 0001 OR: result = a | b.
  - 0010 ADD: result = a + b, modulo 2^64. Carry-out and overflow are discarded from `result`.
  - 0110 SUB: result = a - b, computed as a + ~b + 1, modulo 2^64.
  - 0111 PASS_B: result = b.
  - 1000 LSL: result = a << b[5:0], zero-filled. b[63:6] is ignored.
  - 1001 LSR: result = a >> b[5:0], logical (zero-filled, no sign extension). b[63:6] is ignored.
  - Any other code: result = 0, so zero = 1.
- zero = (result == 64'd0) for every code.
- Operands are raw bit vectors. Signed and unsigned add/sub give identical bits.
- Next-state flag values (nzcv_next):
  - N = result[63].
  - Z = zero.
  - C, ADD: carry out of bit 63.
  - C, SUB: carry out of a + ~b + 1, so C = 1 iff a >= b unsigned.
  - V, ADD: overflow when both operands have the same sign and result[63] differs from it.
  - V, SUB: overflow when a[63] != b[63] and result[63] != a[63].
  - Non-arithmetic ops: C = 0, V = 0.
- Flag register:
  - reset_n low: flags = 4'b0000 immediately (asynchronous), held while reset is low.
  - Rising clk with reset_n high and flags_we = 1: flags <= nzcv_next.
  - flags_we = 0: flags hold.
  - Latency: flags reflect an operation one clk edge after it is presented.
  - Reset deasserting on the same edge as flags_we = 1: the edge is ignored; flags stay 0.
- `result` and `zero` are independent of clk and reset_n. They are valid during reset.
- No X-propagation masking is required. Inputs are assumed known.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_op_t, a 4-bit enum: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_PASSB=4'b0111, ALU_LSL=4'b1000, ALU_LSR=4'b1001.
  - Localparam flag bit indices N=3, Z=2, C=1, V=0.
- One natural sub-module, alu_addsub. It takes a, b and sub, and returns sum[63:0], cout and ovf, using a single adder with b inverted and carry-in = sub.
- The shifter and the logic ops stay inline in alu64.

Test Plan:
- Logic and pass:
  - AND a=FFFF_FFFF_FFFF_FFFF, b=0 -> result 0, zero 1.
  - OR, same operands -> all-ones, zero 0.
  - AND a=FF, b=F0 -> F0.
  - PASS_B b=1 -> 1.
  - Unused code 0011 -> result 0, zero 1.
- Add/sub wrap:
  - ADD a=FFFF_FFFF_FFFF_FFFF, b=1 -> 0, zero 1, nzcv_next=0110.
  - ADD a=b=7FFF_FFFF_FFFF_FFFF -> FFFF_FFFF_FFFF_FFFE, V=1.
  - ADD a=b=8000_0000_0000_0000 -> 0, C=1, V=1.
  - ADD 100 + (-100) -> 0, zero 1.
- Subtraction:
  - a=-1, b=1 -> FFFF_FFFF_FFFF_FFFE.
  - 200-100 -> 100.
  - -100-(-50) -> -50.
  - 50-(-50) -> 100.
  - 5-5 -> 0, nzcv_next=0110.
- Shifts:
  - LSL a=FFFF by 0/1/16 -> FFFF / 1FFFE / FFFF0000.
  - LSL a=FFFE by 63 -> 0, zero 1.
  - LSR FFFF by 1 -> 7FFF.
  - LSR FFFF0000 by 16 -> FFFF.
  - LSR 8000_0000_0000_0000 by 63 -> 1.
  - LSL a=1, b=64 -> 1 (only b[5:0] used).
- Flag register:
  - Assert reset_n=0 mid-simulation -> flags 0000 without waiting for a clk edge.
  - Release reset, SUB 3-5 with flags_we=1, one edge -> flags 1000 (N=1, C=0).
  - flags_we=0 with a new op -> flags unchanged after several edges.
